// File: rtl/lane_traffic_pkg.sv
// Shared limits and the per-lane step period calculation for the lane traffic generator.
// Periods are clamped in a wide signed domain so a high level can never wrap the counter.
package lane_traffic_pkg;

  localparam logic [3:0] LEVEL_MIN = 4'd1;
  localparam logic [3:0] LEVEL_MAX = 4'd15;

  function automatic logic [31:0] lane_period(
    input logic [31:0] base,
    input logic [31:0] stagger,
    input logic [31:0] lstep,
    input logic [31:0] minp,
    input logic [3:0]  lane,
    input logic [3:0]  level
  );
    logic [3:0]         l;
    logic signed [39:0] v;
    l = (level < LEVEL_MIN) ? LEVEL_MIN : level;
    v = $signed({8'd0, base})
      - $signed({36'd0, lane}) * $signed({8'd0, stagger})
      - $signed({36'd0, 4'(l - LEVEL_MIN)}) * $signed({8'd0, lstep});
    if (v < $signed({8'd0, minp})) v = $signed({8'd0, minp});
    return v[31:0];
  endfunction

endpackage

// File: rtl/lane_traffic_mover.sv
// One lane: a down-counter that paces the car and a wrapping position register.
// The live level only affects the value loaded at the next reload.
module lane_mover
  import lane_traffic_pkg::*;
#(
  parameter int                GRID_W       = 20,
  parameter int                X_W          = 5,
  parameter int                CNT_W        = 24,
  parameter bit                DIR          = 1'b1,
  parameter logic [X_W-1:0]    INIT         = '0,
  parameter int                LANE_IDX     = 0,
  parameter logic [CNT_W-1:0]  BASE_PERIOD  = 24'd6_000_000,
  parameter logic [CNT_W-1:0]  LANE_STAGGER = 24'd400_000,
  parameter logic [CNT_W-1:0]  LEVEL_STEP   = 24'd300_000,
  parameter logic [CNT_W-1:0]  MIN_PERIOD   = 24'd500_000
) (
  input  logic           i_Clk,
  input  logic           i_Rst_n,
  input  logic           i_Enable,
  input  logic           i_Restart,
  input  logic [3:0]     i_Level,
  output logic [X_W-1:0] o_X,
  output logic           o_Step
);

  localparam logic [CNT_W-1:0] P_LVL1 = CNT_W'(lane_period(32'(BASE_PERIOD), 32'(LANE_STAGGER),
                                        32'(LEVEL_STEP), 32'(MIN_PERIOD), 4'(LANE_IDX), LEVEL_MIN));

  logic [CNT_W-1:0] r_Cnt;
  logic [X_W-1:0]   r_X;
  logic             r_Step;
  logic [CNT_W-1:0] w_period;
  logic [X_W-1:0]   w_x_next;

  assign w_period = CNT_W'(lane_period(32'(BASE_PERIOD), 32'(LANE_STAGGER),
                    32'(LEVEL_STEP), 32'(MIN_PERIOD), 4'(LANE_IDX), i_Level));

  always_comb begin
    w_x_next = r_X;
    if (DIR) begin
      w_x_next = (r_X == X_W'(GRID_W - 1)) ? '0 : r_X + X_W'(1);
    end else begin
      w_x_next = (r_X == '0) ? X_W'(GRID_W - 1) : r_X - X_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Cnt  <= P_LVL1 - CNT_W'(1);
      r_X    <= INIT;
      r_Step <= 1'b0;
    end else if (i_Restart) begin
      r_Cnt  <= P_LVL1 - CNT_W'(1);
      r_X    <= INIT;
      r_Step <= 1'b0;
    end else if (i_Enable) begin
      if (r_Cnt == '0) begin
        r_Cnt  <= w_period - CNT_W'(1);
        r_X    <= w_x_next;
        r_Step <= 1'b1;
      end else begin
        r_Cnt  <= r_Cnt - CNT_W'(1);
        r_Step <= 1'b0;
      end
    end else begin
      r_Step <= 1'b0;
    end
  end

  assign o_X    = r_X;
  assign o_Step = r_Step;

endmodule

// File: rtl/lane_traffic.sv
// Multi-lane car generator: one lane_mover per lane plus the registered player-collision flag.
// Lane indices at or beyond NUM_LANES never match, so they can never report a hit.
module lane_traffic
  import lane_traffic_pkg::*;
#(
  parameter int                          NUM_LANES    = 4,
  parameter int                          GRID_W       = 20,
  parameter int                          X_W          = 5,
  parameter int                          CNT_W        = 24,
  parameter logic [NUM_LANES-1:0]        LANE_DIR     = 4'b0101,
  parameter logic [NUM_LANES*X_W-1:0]    INIT_X       = {5'd0, 5'd7, 5'd0, 5'd12},
  parameter logic [CNT_W-1:0]            BASE_PERIOD  = 24'd6_000_000,
  parameter logic [CNT_W-1:0]            LANE_STAGGER = 24'd400_000,
  parameter logic [CNT_W-1:0]            LEVEL_STEP   = 24'd300_000,
  parameter logic [CNT_W-1:0]            MIN_PERIOD   = 24'd500_000
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic                     i_Enable,
  input  logic                     i_Restart,
  input  logic [3:0]               i_Level,
  input  logic [X_W-1:0]           i_Player_x,
  input  logic [2:0]               i_Player_lane,
  input  logic                     i_Player_on_road,
  output logic [NUM_LANES*X_W-1:0] o_Car_x,
  output logic [NUM_LANES-1:0]     o_Step,
  output logic                     o_Hit
);

  logic [X_W-1:0]       w_car_x [NUM_LANES];
  logic [NUM_LANES-1:0] w_match;
  logic                 r_Hit;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_mover #(
      .GRID_W      (GRID_W),
      .X_W         (X_W),
      .CNT_W       (CNT_W),
      .DIR         (LANE_DIR[gi]),
      .INIT        (INIT_X[gi*X_W +: X_W]),
      .LANE_IDX    (gi),
      .BASE_PERIOD (BASE_PERIOD),
      .LANE_STAGGER(LANE_STAGGER),
      .LEVEL_STEP  (LEVEL_STEP),
      .MIN_PERIOD  (MIN_PERIOD)
    ) u_lane (
      .i_Clk    (i_Clk),
      .i_Rst_n  (i_Rst_n),
      .i_Enable (i_Enable),
      .i_Restart(i_Restart),
      .i_Level  (i_Level),
      .o_X      (w_car_x[gi]),
      .o_Step   (o_Step[gi])
    );

    assign o_Car_x[gi*X_W +: X_W] = w_car_x[gi];
    assign w_match[gi] = i_Player_on_road && (i_Player_lane == 3'(gi)) &&
                         (w_car_x[gi] == i_Player_x);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_Hit <= 1'b0;
    else          r_Hit <= |w_match;
  end

  assign o_Hit = r_Hit;

endmodule
